// File: rtl/fp_mult_pipe_pkg.sv
`default_nettype none
// ============================================================================
// fp_pkg : shared constants and range helper for the fixed-point datapath
// Rev 1.0
// ============================================================================
package fp_pkg;

   localparam bit RND_TRUNC   = 1'b0;
   localparam bit RND_HALF_UP = 1'b1;
   localparam bit SAT_WRAP    = 1'b0;
   localparam bit SAT_CLAMP   = 1'b1;

   // Largest or smallest two's-complement value representable in 'width' bits.
   function automatic logic signed [63:0] fp_bound(input int width, input bit want_max);
      if (want_max)
         fp_bound = (64'sd1 <<< (width - 1)) - 64'sd1;
      else
         fp_bound = -(64'sd1 <<< (width - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mult_pipe_if.sv
`default_nettype none
// ============================================================================
// fp_mult_pipe_if : operand/result valid-ready streams of the multiplier
// Rev 1.0
// ============================================================================
interface fp_mult_pipe_if #(
   parameter int WI1 = 4,
   parameter int WF1 = 16,
   parameter int WI2 = 4,
   parameter int WF2 = 16,
   parameter int WIO = 4,
   parameter int WFO = 16
);
   logic                        in_valid;
   logic                        in_ready;
   logic signed [WI1+WF1-1:0]   in1;
   logic signed [WI2+WF2-1:0]   in2;
   logic                        out_valid;
   logic                        out_ready;
   logic signed [WIO+WFO-1:0]   out;
   logic                        ovf;

   modport master (
      output in_valid, in1, in2, out_ready,
      input  in_ready, out_valid, out, ovf
   );

   modport slave (
      input  in_valid, in1, in2, out_ready,
      output in_ready, out_valid, out, ovf
   );
endinterface
`default_nettype wire

// File: rtl/fp_mult_pipe_requant.sv
`default_nettype none
// ============================================================================
// fp_requant : combinational shift / round / saturate to a narrower Q format
// Rev 1.0
// ============================================================================
module fp_requant
   import fp_pkg::*;
#(
   parameter int IN_W   = 40,
   parameter int IN_FP  = 32,
   parameter int OUT_WI = 4,
   parameter int OUT_WF = 16,
   parameter bit RND    = RND_HALF_UP,
   parameter bit SAT    = SAT_CLAMP
) (
   input  logic signed [IN_W-1:0]          p,
   output logic signed [OUT_WI+OUT_WF-1:0] q,
   output logic                            ovf
);
   localparam int OUT_W = OUT_WI + OUT_WF;
   localparam int LSH   = (OUT_WF >= IN_FP) ? OUT_WF - IN_FP : 0;
   localparam int RSH   = (OUT_WF <  IN_FP) ? IN_FP - OUT_WF : 0;
   // Wide enough to hold the rounded/shifted value and at least one guard bit above OUT_W.
   localparam int EXT_W = (((IN_W + 1 + LSH) > OUT_W) ? (IN_W + 1 + LSH) : OUT_W) + 1;

   localparam logic [OUT_W-1:0] c_max = OUT_W'(fp_bound(OUT_W, 1'b1));
   localparam logic [OUT_W-1:0] c_min = OUT_W'(fp_bound(OUT_W, 1'b0));

   logic signed [EXT_W-1:0]     w_ext;
   logic [EXT_W-OUT_W:0]        w_top;
   logic                        w_in_range;

   generate
      if (RSH > 0) begin : g_round
         localparam logic [IN_W:0] c_half = (RND == RND_HALF_UP) ? ((IN_W+1)'(1) << (RSH - 1)) : '0;
         logic signed [IN_W:0]    w_sum;
         logic signed [EXT_W-1:0] w_wide;
         assign w_sum  = {p[IN_W-1], p} + c_half;
         assign w_wide = {{(EXT_W-IN_W-1){w_sum[IN_W]}}, w_sum};
         assign w_ext  = w_wide >>> RSH;
      end else begin : g_shift
         assign w_ext = {{(EXT_W-IN_W){p[IN_W-1]}}, p} <<< LSH;
      end
   endgenerate

   // Representable exactly when every bit from the output sign upward agrees.
   assign w_top      = w_ext[EXT_W-1:OUT_W-1];
   assign w_in_range = (&w_top) | ~(|w_top);

   always_comb begin
      ovf = ~w_in_range;
      if (w_in_range || (SAT == SAT_WRAP))
         q = w_ext[OUT_W-1:0];
      else
         q = w_ext[EXT_W-1] ? c_min : c_max;
   end
endmodule
`default_nettype wire

// File: rtl/fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// fp_mult_pipe : 3-stage signed fixed-point multiplier with requantised output
// Rev 1.0
// ============================================================================
module fp_mult_pipe
   import fp_pkg::*;
#(
   parameter int WI1 = 4,
   parameter int WF1 = 16,
   parameter int WI2 = 4,
   parameter int WF2 = 16,
   parameter int WIO = 4,
   parameter int WFO = 16,
   parameter bit RND = RND_HALF_UP,
   parameter bit SAT = SAT_CLAMP
) (
   input  logic          clk,
   input  logic          rst,
   fp_mult_pipe_if.slave bus
);
   localparam int W  = WI1 + WI2 + WF1 + WF2;
   localparam int FP = WF1 + WF2;
   localparam int WO = WIO + WFO;

   logic                      r_v1, r_v2, r_v3;
   logic signed [WI1+WF1-1:0] r_a;
   logic signed [WI2+WF2-1:0] r_b;
   logic signed [W-1:0]       r_p;
   logic signed [WO-1:0]      r_out;
   logic                      r_ovf;
   logic signed [WO-1:0]      w_q;
   logic                      w_ovf;
   logic                      w_adv;

   // One global enable: the whole pipe moves or the whole pipe holds.
   assign w_adv        = !r_v3 || bus.out_ready;
   assign bus.in_ready = w_adv;

   fp_requant #(
      .IN_W   (W),
      .IN_FP  (FP),
      .OUT_WI (WIO),
      .OUT_WF (WFO),
      .RND    (RND),
      .SAT    (SAT)
   ) u_requant (
      .p   (r_p),
      .q   (w_q),
      .ovf (w_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_v3  <= 1'b0;
         r_a   <= '0;
         r_b   <= '0;
         r_p   <= '0;
         r_out <= '0;
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         r_v1  <= bus.in_valid;
         r_a   <= bus.in1;
         r_b   <= bus.in2;
         r_v2  <= r_v1;
         r_p   <= W'(r_a) * W'(r_b);
         r_v3  <= r_v2;
         r_out <= w_q;
         r_ovf <= w_ovf;
      end
   end

   assign bus.out_valid = r_v3;
   assign bus.out       = r_out;
   assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// tb_fp_mult_pipe : directed and randomized checks against an arithmetic model
// Rev 1.0
// ============================================================================
module tb_fp_mult_pipe;
   import fp_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fp_mult_pipe_if #(.WI1(4), .WF1(16), .WI2(4), .WF2(16), .WIO(4), .WFO(16)) bus_a();
   fp_mult_pipe_if #(.WI1(4), .WF1(16), .WI2(4), .WF2(16), .WIO(4), .WFO(16)) bus_b();
   fp_mult_pipe_if #(.WI1(4), .WF1(16), .WI2(4), .WF2(16), .WIO(2), .WFO(8))  bus_c();

   fp_mult_pipe #(.WI1(4), .WF1(16), .WI2(4), .WF2(16), .WIO(4), .WFO(16),
                  .RND(RND_HALF_UP), .SAT(SAT_CLAMP)) u_def (.clk(clk), .rst(rst), .bus(bus_a));
   fp_mult_pipe #(.WI1(4), .WF1(16), .WI2(4), .WF2(16), .WIO(4), .WFO(16),
                  .RND(RND_TRUNC), .SAT(SAT_WRAP)) u_tw (.clk(clk), .rst(rst), .bus(bus_b));
   fp_mult_pipe #(.WI1(4), .WF1(16), .WI2(4), .WF2(16), .WIO(2), .WFO(8),
                  .RND(RND_HALF_UP), .SAT(SAT_CLAMP)) u_fmt (.clk(clk), .rst(rst), .bus(bus_c));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Real-number semantics: product, floor/half-up scaling, then clamp or wrap.
   function automatic void ref_mult(input longint a, input longint b,
                                    input int wf1, input int wf2, input int wio, input int wfo,
                                    input bit rnd, input bit sat,
                                    output logic [63:0] o, output logic v);
      longint p, q, hi, lo;
      int fp, wo;
      fp = wf1 + wf2;
      wo = wio + wfo;
      p  = a * b;
      if (wfo < fp) begin
         if (rnd) p = p + (longint'(1) << (fp - wfo - 1));
         q = p >>> (fp - wfo);
      end else begin
         q = p <<< (wfo - fp);
      end
      hi = (longint'(1) << (wo - 1)) - 1;
      lo = -(longint'(1) << (wo - 1));
      v  = (q > hi) || (q < lo);
      if (v && sat) q = (q > hi) ? hi : lo;
      o = 64'(q) & ((64'd1 << wo) - 64'd1);
   endfunction

   function automatic logic [19:0] rand_op();
      logic [31:0] r;
      r = $urandom;
      case (r[31:30])
         2'd0:    rand_op = r[19:0];
         2'd1:    rand_op = {{3{r[16]}}, r[16:0]};
         default: rand_op = {{5{r[14]}}, r[14:0]};
      endcase
   endfunction

   // ---------------- scoreboard ----------------
   logic [63:0] qa_o[$], qb_o[$];
   logic        qa_v[$], qb_v[$];
   logic        stall_a = 1'b0;
   logic [63:0] held_out;
   logic        held_ovf;

   always @(negedge clk) begin
      logic [63:0] o;
      logic        v;
      if (rst) begin
         qa_o.delete(); qa_v.delete(); qb_o.delete(); qb_v.delete();
         stall_a = 1'b0;
      end else begin
         if (stall_a) begin
            check("hold_out", 64'($unsigned(bus_a.out)), held_out);
            check("hold_ovf", 64'(bus_a.ovf), 64'(held_ovf));
         end
         if (bus_a.out_valid && bus_a.out_ready) begin
            if (qa_o.size() == 0) check("spurious_a", 64'(bus_a.out_valid), 64'd0);
            else begin
               check("def_out", 64'($unsigned(bus_a.out)), qa_o.pop_front());
               check("def_ovf", 64'(bus_a.ovf), 64'(qa_v.pop_front()));
            end
         end
         if (bus_b.out_valid && bus_b.out_ready) begin
            if (qb_o.size() == 0) check("spurious_b", 64'(bus_b.out_valid), 64'd0);
            else begin
               check("tw_out", 64'($unsigned(bus_b.out)), qb_o.pop_front());
               check("tw_ovf", 64'(bus_b.ovf), 64'(qb_v.pop_front()));
            end
         end
         stall_a  = bus_a.out_valid && !bus_a.out_ready;
         held_out = 64'($unsigned(bus_a.out));
         held_ovf = bus_a.ovf;
         if (bus_a.in_valid && bus_a.in_ready) begin
            ref_mult(longint'(bus_a.in1), longint'(bus_a.in2), 16, 16, 4, 16, 1'b1, 1'b1, o, v);
            qa_o.push_back(o); qa_v.push_back(v);
         end
         if (bus_b.in_valid && bus_b.in_ready) begin
            ref_mult(longint'(bus_b.in1), longint'(bus_b.in2), 16, 16, 4, 16, 1'b0, 1'b0, o, v);
            qb_o.push_back(o); qb_v.push_back(v);
         end
      end
   end

   task automatic drive(input logic v, input logic [19:0] x, input logic [19:0] y, input logic rdy);
      bus_a.in_valid = v; bus_a.in1 = x; bus_a.in2 = y; bus_a.out_ready = rdy;
      bus_b.in_valid = v; bus_b.in1 = x; bus_b.in2 = y; bus_b.out_ready = rdy;
   endtask

   // Single pair through an idle pipe; checks latency and both rounding/overflow variants.
   task automatic direct(input string tag, input logic [19:0] x, input logic [19:0] y,
                         input logic [63:0] ea, input logic va, input logic [63:0] eb, input logic vb);
      int n;
      @(posedge clk); #1;
      drive(1'b1, x, y, 1'b1);
      @(posedge clk); #1;
      drive(1'b0, x, y, 1'b1);
      n = 1;
      while (!bus_a.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_lat"},     64'(n), 64'd3);
      check({tag, "_def_out"}, 64'($unsigned(bus_a.out)), ea);
      check({tag, "_def_ovf"}, 64'(bus_a.ovf), 64'(va));
      check({tag, "_tw_out"},  64'($unsigned(bus_b.out)), eb);
      check({tag, "_tw_ovf"},  64'(bus_b.ovf), 64'(vb));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int n, acc, cyc;
      logic pend, v;
      logic [19:0] x, y;

      drive(1'b0, '0, '0, 1'b1);
      bus_c.in_valid = 1'b0; bus_c.in1 = '0; bus_c.in2 = '0; bus_c.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
      check("rst_in_ready",  64'(bus_a.in_ready),  64'd1);
      check("rst_out",       64'($unsigned(bus_a.out)), 64'd0);
      check("rst_ovf",       64'(bus_a.ovf),       64'd0);
      rst = 1'b0;

      direct("exact",   20'h18000, 20'h20000, 64'h30000, 1'b0, 64'h30000, 1'b0);
      direct("sat3x3",  20'h30000, 20'h30000, 64'h7FFFF, 1'b1, 64'h90000, 1'b1);
      direct("sat8x8",  20'h80000, 20'h80000, 64'h7FFFF, 1'b1, 64'h00000, 1'b1);
      direct("rnd_pos", 20'h00001, 20'h08000, 64'h00001, 1'b0, 64'h00000, 1'b0);
      direct("rnd_neg", 20'hFFFFF, 20'h08000, 64'h00000, 1'b0, 64'hFFFFF, 1'b0);

      // Narrow output format: 1.25 * 0.75 = 0.9375 in Q2.8.
      @(posedge clk); #1;
      bus_c.in_valid = 1'b1; bus_c.in1 = 20'h14000; bus_c.in2 = 20'h0C000;
      @(posedge clk); #1;
      bus_c.in_valid = 1'b0;
      n = 1;
      while (!bus_c.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("fmt_lat", 64'(n), 64'd3);
      check("fmt_out", 64'($unsigned(bus_c.out)), 64'h0F0);
      check("fmt_ovf", 64'(bus_c.ovf), 64'd0);

      // Random stream under random backpressure; inputs held until accepted.
      acc = 0; cyc = 0; pend = 1'b0; v = 1'b0; x = '0; y = '0;
      while (acc < 30 && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
         if (!pend) begin
            v = ($urandom % 4) != 0;
            x = rand_op();
            y = rand_op();
         end
         drive(v, x, y, 1'($urandom % 2));
         @(negedge clk);
         if (v && bus_a.in_ready) begin
            acc++;
            pend = 1'b0;
         end else begin
            pend = v;
         end
      end
      check("stream_accepted", 64'(acc), 64'd30);
      @(posedge clk); #1;
      drive(1'b0, '0, '0, 1'b1);
      n = 0;
      while ((qa_o.size() != 0 || qb_o.size() != 0) && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_a", 64'(qa_o.size()), 64'd0);
      check("drain_b", 64'(qb_o.size()), 64'd0);

      // Fill the pipe while stalled, then reset with three items in flight.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         drive(1'b1, rand_op(), rand_op(), 1'b0);
      end
      @(posedge clk); #1;
      drive(1'b0, '0, '0, 1'b0);
      check("full_in_ready",  64'(bus_a.in_ready),  64'd0);
      check("full_out_valid", 64'(bus_a.out_valid), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1'b1, 20'h30000, 20'h30000, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, '0, '0, 1'b1);
      check("midrst_out_valid", 64'(bus_a.out_valid), 64'd0);
      check("midrst_out",       64'($unsigned(bus_a.out)), 64'd0);
      check("midrst_in_ready",  64'(bus_a.in_ready),  64'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("no_stale", 64'(bus_a.out_valid | bus_b.out_valid), 64'd0);
      end
      direct("post_rst", 20'hE8000, 20'h20000, 64'hD0000, 1'b0, 64'hD0000, 1'b0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
